// File: rtl/seg7_scan_mux_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment patterns are active low, ordered {a,b,c,d,e,f,g}.
package seg7_scan_mux_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    localparam logic [6:0] HEX_0 = 7'b0000001;
    localparam logic [6:0] HEX_1 = 7'b1001111;
    localparam logic [6:0] HEX_2 = 7'b0010010;
    localparam logic [6:0] HEX_3 = 7'b0000110;
    localparam logic [6:0] HEX_4 = 7'b1001100;
    localparam logic [6:0] HEX_5 = 7'b0100100;
    localparam logic [6:0] HEX_6 = 7'b0100000;
    localparam logic [6:0] HEX_7 = 7'b0001111;
    localparam logic [6:0] HEX_8 = 7'b0000000;
    localparam logic [6:0] HEX_9 = 7'b0000100;
    localparam logic [6:0] HEX_A = 7'b0001000;
    localparam logic [6:0] HEX_B = 7'b1100000;
    localparam logic [6:0] HEX_C = 7'b0110001;
    localparam logic [6:0] HEX_D = 7'b1000010;
    localparam logic [6:0] HEX_E = 7'b0110000;
    localparam logic [6:0] HEX_F = 7'b0111000;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low {a..g} segment pattern.
module seg7_hex_decode
    import seg7_scan_mux_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        case (nibble)
            4'h0: seg_c = HEX_0;
            4'h1: seg_c = HEX_1;
            4'h2: seg_c = HEX_2;
            4'h3: seg_c = HEX_3;
            4'h4: seg_c = HEX_4;
            4'h5: seg_c = HEX_5;
            4'h6: seg_c = HEX_6;
            4'h7: seg_c = HEX_7;
            4'h8: seg_c = HEX_8;
            4'h9: seg_c = HEX_9;
            4'hA: seg_c = HEX_A;
            4'hB: seg_c = HEX_B;
            4'hC: seg_c = HEX_C;
            4'hD: seg_c = HEX_D;
            4'hE: seg_c = HEX_E;
            4'hF: seg_c = HEX_F;
            default: seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver: per-frame input snapshot,
// leading-zero blanking, anti-ghost blank window and PWM brightness.
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int unsigned N_DIGITS  = 6,
    parameter int unsigned DIV_W     = 15,
    parameter int unsigned BR_W      = 4,
    parameter int unsigned BLANK_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  lz_en,
    input  logic [BR_W-1:0]       brightness,
    output logic [7:0]            seg,
    output logic [N_DIGITS-1:0]   scan,
    output logic                  frame
);

    localparam int unsigned IDX_W = $clog2(N_DIGITS);

    logic [DIV_W-1:0]      phase;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] snap_digits;
    logic [N_DIGITS-1:0]   snap_dp;
    logic [N_DIGITS-1:0]   snap_en;
    logic                  snap_lz;
    logic [BR_W-1:0]       snap_br;

    logic                  wrap_c;
    logic                  last_digit_c;
    logic                  frame_start_c;
    logic [N_DIGITS-1:0]   lz_blank_c;
    logic                  zero_above_c;
    logic [3:0]            nibble_c;
    logic                  dp_c;
    logic                  en_c;
    logic                  blank_c;
    logic [6:0]            hex_seg_c;
    logic                  bright_ok_c;
    logic                  drive_c;

    assign wrap_c        = (phase == {DIV_W{1'b1}});
    assign last_digit_c  = (idx == IDX_W'(N_DIGITS - 1));
    assign frame_start_c = wrap_c && last_digit_c;

    // Slot timer and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            idx   <= '0;
        end else begin
            phase <= phase + DIV_W'(1);
            if (wrap_c) begin
                idx <= last_digit_c ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Inputs are only sampled when entering digit 0, so a frame never tears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_en     <= '0;
            snap_lz     <= 1'b0;
            snap_br     <= '0;
        end else if (frame_start_c) begin
            snap_digits <= digits_in;
            snap_dp     <= dp_in;
            snap_en     <= digit_en;
            snap_lz     <= lz_en;
            snap_br     <= brightness;
        end
    end

    // Leading-zero mask: walk down from the top digit; digit 0 is never blanked
    always_comb begin
        lz_blank_c   = '0;
        zero_above_c = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_above_c  = zero_above_c && (snap_digits[4*k +: 4] == 4'h0);
            lz_blank_c[k] = snap_lz && zero_above_c;
        end
    end

    // Select the current digit's attributes
    always_comb begin
        nibble_c = 4'h0;
        dp_c     = 1'b0;
        en_c     = 1'b0;
        blank_c  = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                nibble_c = snap_digits[4*k +: 4];
                dp_c     = snap_dp[k];
                en_c     = snap_en[k];
                blank_c  = lz_blank_c[k];
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble (nibble_c),
        .seg_c  (hex_seg_c)
    );

    // PWM compares the slot's top phase bits against brightness; all-ones bypasses it
    assign bright_ok_c = (snap_br == {BR_W{1'b1}}) || (phase[DIV_W-1 -: BR_W] < snap_br);
    assign drive_c     = (phase >= DIV_W'(BLANK_CYC)) && en_c && bright_ok_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg   <= SEG_BLANK;
            scan  <= '1;
            frame <= 1'b0;
        end else begin
            frame <= frame_start_c;
            if (drive_c) begin
                scan <= ~(N_DIGITS'(1) << idx);
                seg  <= {(blank_c ? SEG_OFF : hex_seg_c), ~dp_c};
            end else begin
                scan <= '1;
                seg  <= SEG_BLANK;
            end
        end
    end

endmodule
